// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter write port among NUM_REQ byte streams.
// Optional build macro UART_TX_ARB_TAG_EN prefixes every packet with its requester index in ASCII.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned BUSY_WAIT_CYC = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ*8-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_uart_wr,
  output logic [7:0]             o_uart_data,
  input  logic                   i_uart_busy,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_active
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
`ifdef UART_TX_ARB_TAG_EN
    , S_TAG     = 3'd5
`endif
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic                 last_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 arb_found;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W-1:0]     cand;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!arb_found && i_req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign o_req_ready = (state_q == S_FETCH) ? o_grant : '0;
  assign o_active    = (state_q != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      o_uart_wr   <= 1'b0;
      o_uart_data <= 8'h00;
      o_grant     <= '0;
    end else begin
      o_uart_wr <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_found && !i_uart_busy) begin
            idx_q   <= arb_idx;
            o_grant <= NUM_REQ'(1'b1) << arb_idx;
`ifdef UART_TX_ARB_TAG_EN
            state_q <= S_TAG;
`else
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        // Tag byte is never the end of a packet.
        S_TAG: begin
          o_uart_data <= 8'h30 + 8'(idx_q);
          last_q      <= 1'b0;
          o_uart_wr   <= 1'b1;
          state_q     <= S_ISSUE;
        end
`endif
        S_FETCH: begin
          if (i_req_valid[idx_q]) begin
            o_uart_data <= i_req_data[{idx_q, 3'b000} +: 8];
            last_q      <= i_req_last[idx_q];
            o_uart_wr   <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_BUSY;
        end
        // Give up waiting for busy after BUSY_WAIT_CYC idle cycles: byte already gone.
        S_WAIT_BUSY: begin
          if (i_uart_busy) begin
            state_q <= S_WAIT_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if ((32'(cnt_q) + 32'd1) >= BUSY_WAIT_CYC) begin
              state_q <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!i_uart_busy) begin
            if (last_q) begin
              ptr_q   <= (32'(idx_q) == (NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
              o_grant <= '0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
